mem_lsu: RTL and testbench

- MEM-stage load/store unit between the EX/MEM pipeline register and mem_wb.
- Decodes the memory op carried with the instruction and drives a variable-latency req/ack data bus.
- Aligns and extends load data, and raises a stall request while the access is outstanding.
- Non-memory instructions pass through combinationally in the same cycle. The results feed mem_wb's wdata0/mem_wd0/mem_wreg0/mem_pc inputs.

---
 rtl/mem_lsu.sv | 174 +++++++++++++++++
 tb/tb_mem_lsu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: decodes the memory op, drives a req/ack data bus,
// aligns/extends load data and stalls the pipeline while the access is outstanding.
module mem_lsu #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic [3:0]        mem_op,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_sdata,
   input  logic [31:0]       mem_wdata,
   input  logic [4:0]        mem_wd,
   input  logic              mem_wreg,
   input  logic [31:0]       mem_pc,
   output logic [31:0]       wdata0,
   output logic [4:0]        mem_wd0,
   output logic              mem_wreg0,
   output logic [31:0]       mem_pc_o,
   output logic              stallreq_mem,
   output logic              excp_adel,
   output logic              excp_ades,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [3:0]        dbus_sel,
   output logic [31:0]       dbus_wdata,
   input  logic              dbus_ack,
   input  logic [31:0]       dbus_rdata
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                          OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

   state_t            state_q, state_d;
   logic [31:0]       load_q, load_d;
   logic              ld_en;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        sel_q;
   logic [31:0]       wdata_q;
   logic [3:0]        op_q;
   logic [1:0]        lane_q;

   logic              is_load, is_store, mis, issue;
   logic [3:0]        sel_c;
   logic [31:0]       wdata_c;
   logic              unused_stall;

   assign unused_stall = ^{stall[5], stall[3:0]};

   // Pick the addressed byte/half of a full bus word and extend it
   function automatic logic [31:0] extend(input logic [3:0] op, input logic [1:0] lane,
                                          input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[{lane, 3'b000} +: 8];
      h = lane[1] ? d[31:16] : d[15:0];
      case (op)
         OP_LB:   extend = {{24{b[7]}}, b};
         OP_LBU:  extend = {24'd0, b};
         OP_LH:   extend = {{16{h[15]}}, h};
         OP_LHU:  extend = {16'd0, h};
         default: extend = d;
      endcase
   endfunction

   // Op decode, alignment check and bus lane/data encoding
   always_comb begin
      is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
      is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
      case (mem_op)
         OP_LH, OP_LHU, OP_SH: mis = mem_addr[0];
         OP_LW, OP_SW:         mis = |mem_addr[1:0];
         default:              mis = 1'b0;
      endcase
      issue = (is_load || is_store) && !mis;
      case (mem_op)
         OP_LB, OP_LBU, OP_SB: sel_c = 4'b0001 << mem_addr[1:0];
         OP_LH, OP_LHU, OP_SH: sel_c = mem_addr[1] ? 4'b1100 : 4'b0011;
         default:              sel_c = 4'b1111;
      endcase
      case (mem_op)
         OP_SB:   wdata_c = {4{mem_sdata[7:0]}};
         OP_SH:   wdata_c = {2{mem_sdata[15:0]}};
         default: wdata_c = mem_sdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      ld_en        = 1'b0;
      load_d       = 32'd0;
      wdata0       = 32'd0;
      mem_wd0      = 5'd0;
      mem_wreg0    = 1'b0;
      mem_pc_o     = 32'd0;
      stallreq_mem = 1'b0;
      excp_adel    = 1'b0;
      excp_ades    = 1'b0;
      dbus_req     = 1'b0;
      dbus_we      = 1'b0;
      dbus_addr    = '0;
      dbus_sel     = 4'd0;
      dbus_wdata   = 32'd0;
      if (!rst) begin
         mem_wd0   = mem_wd;
         mem_pc_o  = mem_pc;
         excp_adel = is_load && mis;
         excp_ades = is_store && mis;
         wdata0    = mem_wdata;
         mem_wreg0 = mem_wreg && !is_store && !mis;
         case (state_q)
            IDLE: begin
               if (issue) begin
                  dbus_req     = 1'b1;
                  stallreq_mem = 1'b1;
                  dbus_we      = is_store;
                  dbus_addr    = ADDR_W'(mem_addr);
                  dbus_sel     = sel_c;
                  dbus_wdata   = wdata_c;
                  load_d       = extend(mem_op, mem_addr[1:0], dbus_rdata);
                  ld_en        = dbus_ack;
                  state_d      = dbus_ack ? DONE : WAIT;
               end
            end
            WAIT: begin
               dbus_req     = 1'b1;
               stallreq_mem = 1'b1;
               dbus_we      = we_q;
               dbus_addr    = addr_q;
               dbus_sel     = sel_q;
               dbus_wdata   = wdata_q;
               load_d       = extend(op_q, lane_q, dbus_rdata);
               ld_en        = dbus_ack;
               if (dbus_ack) state_d = DONE;
            end
            DONE: begin
               if (is_load) wdata0 = load_q;
               if (!stall[4]) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Bus fields are latched at issue so they stay stable through WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         load_q  <= 32'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         sel_q   <= 4'd0;
         wdata_q <= 32'd0;
         op_q    <= 4'd0;
         lane_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         if (ld_en) load_q <= load_d;
         if (state_q == IDLE && issue) begin
            we_q    <= is_store;
            addr_q  <= ADDR_W'(mem_addr);
            sel_q   <= sel_c;
            wdata_q <= wdata_c;
            op_q    <= mem_op;
            lane_q  <= mem_addr[1:0];
         end
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: table of single-cycle vectors, directed
// multi-cycle sequences and randomized transactions against a reference model.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr, mem_sdata, mem_wdata, mem_pc;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] wdata0, mem_pc_o, dbus_wdata, dbus_rdata;
   logic [4:0]  mem_wd0;
   logic        mem_wreg0, stallreq_mem, excp_adel, excp_ades;
   logic        dbus_req, dbus_we, dbus_ack;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_sel;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_lsu #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .mem_op(mem_op), .mem_addr(mem_addr),
      .mem_sdata(mem_sdata), .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
      .mem_pc(mem_pc), .wdata0(wdata0), .mem_wd0(mem_wd0), .mem_wreg0(mem_wreg0),
      .mem_pc_o(mem_pc_o), .stallreq_mem(stallreq_mem), .excp_adel(excp_adel),
      .excp_ades(excp_ades), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
   );

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference model: access size in bytes (0 = not a memory op)
   function automatic int op_size(input logic [3:0] op);
      if (op == 1 || op == 2 || op == 6) return 1;
      if (op == 3 || op == 4 || op == 7) return 2;
      if (op == 5 || op == 8) return 4;
      return 0;
   endfunction

   function automatic bit op_store(input logic [3:0] op);
      return op >= 6 && op <= 8;
   endfunction

   function automatic bit issues(input logic [3:0] op, input logic [31:0] addr);
      int s;
      s = op_size(op);
      return s != 0 && (addr % s) == 0;
   endfunction

   function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
      int s, off;
      s   = op_size(op);
      off = int'(addr % 4);
      if (s == 1) return 4'(1 << off);
      if (s == 2) return (off == 0) ? 4'd3 : 4'd12;
      return 4'd15;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
      if (op == 6) return (d % 256) * 32'h0101_0101;
      if (op == 7) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                          input logic [31:0] rd);
      longint v;
      int off;
      off = int'(addr % 4);
      case (op)
         1, 2: begin
            v = (longint'(rd) >> (8 * off)) % 256;
            if (op == 1 && v >= 128) v = v - 256;
         end
         3, 4: begin
            v = (longint'(rd) >> (8 * off)) % 65536;
            if (op == 3 && v >= 32768) v = v - 65536;
         end
         default: v = longint'(rd);
      endcase
      return 32'(v);
   endfunction

   function automatic logic [159:0] all_outs();
      return 160'({wdata0, mem_wd0, mem_wreg0, mem_pc_o, stallreq_mem, excp_adel, excp_ades,
                   dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata});
   endfunction

   // Check one cycle of an op that must not touch the bus
   task automatic check_passive(input string name);
      logic [3:0] exp_flags;
      bit ld, st, mis;
      st = op_store(mem_op);
      ld = op_size(mem_op) != 0 && !st;
      mis = op_size(mem_op) != 0 && !issues(mem_op, mem_addr);
      exp_flags = {1'b0, 1'b0, ld && mis, st && mis};
      chk({name, ".req_stall_exc"}, 160'({dbus_req, stallreq_mem, excp_adel, excp_ades}),
          160'(exp_flags));
      chk({name, ".wreg0"}, 160'(mem_wreg0), 160'(mem_wreg && !mis && !st));
      chk({name, ".wd_pc"}, 160'({mem_wd0, mem_pc_o}), 160'({mem_wd, mem_pc}));
      if (op_size(mem_op) == 0) chk({name, ".wdata0"}, 160'(wdata0), 160'(mem_wdata));
   endtask

   // Full memory transaction: request phase, ack after ack_dly extra cycles, DONE held hold cycles
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata, input int ack_dly,
                         input int hold, input bit spurious, input bit wreg);
      logic [31:0] exp_res;
      mem_op = op; mem_addr = addr; mem_sdata = sdata; mem_wreg = wreg;
      mem_wdata = $urandom; mem_wd = 5'($urandom); mem_pc = $urandom; stall = 6'd0;
      exp_res = m_load(op, addr, rdata);
      for (int i = 0; i <= ack_dly; i++) begin
         dbus_ack = (i == ack_dly);
         dbus_rdata = (i == ack_dly) ? rdata : $urandom;
         #1;
         chk({name, ".bus"}, 160'({dbus_req, stallreq_mem, dbus_we, dbus_sel, dbus_addr, dbus_wdata}),
             160'({1'b1, 1'b1, op_store(op), m_sel(op, addr), addr, m_wdata(op, sdata)}));
         next_cycle();
      end
      for (int h = 0; h <= hold; h++) begin
         stall = (h < hold) ? 6'b011111 : 6'd0;
         dbus_ack = spurious && (h < hold);
         dbus_rdata = $urandom;
         #1;
         chk({name, ".done_req_stall"}, 160'({dbus_req, stallreq_mem}), 160'(0));
         chk({name, ".done_wreg0"}, 160'(mem_wreg0), 160'(wreg && !op_store(op)));
         if (!op_store(op)) chk({name, ".done_wdata0"}, 160'(wdata0), 160'(exp_res));
         next_cycle();
      end
      dbus_ack = 1'b0;
      stall = 6'd0;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wreg;
      logic [3:0]  exp;   // {mem_wreg0, adel, ades, dbus_req}
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{4'd0,  32'h0,     32'h1234,      1'b1, 4'b1000};
      vecs[1] = '{4'd0,  32'h3,     32'hCAFE_0001, 1'b0, 4'b0000};
      vecs[2] = '{4'd9,  32'h100,   32'h5555_AAAA, 1'b1, 4'b1000};
      vecs[3] = '{4'd15, 32'h200,   32'h0BAD_F00D, 1'b1, 4'b1000};
      vecs[4] = '{4'd5,  32'h6,     32'h1,         1'b1, 4'b0100};
      vecs[5] = '{4'd3,  32'h101,   32'h2,         1'b1, 4'b0100};
      vecs[6] = '{4'd4,  32'h3,     32'h3,         1'b1, 4'b0100};
      vecs[7] = '{4'd8,  32'h2,     32'h4,         1'b1, 4'b0010};
      vecs[8] = '{4'd7,  32'h7,     32'h5,         1'b1, 4'b0010};
      vecs[9] = '{4'd5,  32'h5,     32'h6,         1'b0, 4'b0100};

      // Reset with a live aligned load on the inputs: everything must read zero
      rst = 1'b1; stall = 6'd0; mem_op = 4'd5; mem_addr = 32'h40; mem_sdata = 32'h1;
      mem_wdata = 32'hFFFF_FFFF; mem_wd = 5'd7; mem_wreg = 1'b1; mem_pc = 32'h400;
      dbus_ack = 1'b0; dbus_rdata = 32'h0;
      next_cycle();
      chk("reset_outputs", all_outs(), 160'(0));
      next_cycle();
      chk("reset_outputs_2", all_outs(), 160'(0));
      mem_op = 4'd0;
      rst = 1'b0;
      next_cycle();

      // Table: ops that never touch the bus
      foreach (vecs[i]) begin
         mem_op = vecs[i].op; mem_addr = vecs[i].addr; mem_wdata = vecs[i].wdata;
         mem_wreg = vecs[i].wreg; mem_wd = 5'(i + 3); mem_pc = 32'h1000 + 32'(4 * i);
         mem_sdata = $urandom;
         #1;
         chk($sformatf("vec%0d.flags", i), 160'({mem_wreg0, excp_adel, excp_ades, dbus_req}),
             160'(vecs[i].exp));
         chk($sformatf("vec%0d.stallreq", i), 160'(stallreq_mem), 160'(0));
         if (vecs[i].op == 0 || vecs[i].op >= 9)
            chk($sformatf("vec%0d.wdata0", i), 160'(wdata0), 160'(vecs[i].wdata));
         chk($sformatf("vec%0d.wd_pc", i), 160'({mem_wd0, mem_pc_o}),
             160'({5'(i + 3), 32'h1000 + 32'(4 * i)}));
         next_cycle();
      end

      // Directed multi-cycle sequences
      run_op("lb_103",   4'd1, 32'h103, 32'h0, 32'h80FF_FFFF, 3, 0, 1'b0, 1'b1);
      run_op("lbu_103",  4'd2, 32'h103, 32'h0, 32'h80FF_FFFF, 3, 0, 1'b0, 1'b1);
      run_op("sh_202",   4'd7, 32'h202, 32'hAAAA_BEEF, 32'h0, 0, 0, 1'b0, 1'b1);
      run_op("lw_hold",  4'd5, 32'h300, 32'h0, 32'hDEAD_BEEF, 1, 2, 1'b1, 1'b1);
      run_op("lh_neg",   4'd3, 32'h12,  32'h0, 32'h8001_7FFF, 0, 0, 1'b0, 1'b1);
      run_op("sb_001",   4'd6, 32'h1,   32'h1234_56A5, 32'h0, 2, 1, 1'b0, 1'b1);

      // Reset during WAIT abandons the access; a late ack must be ignored
      mem_op = 4'd5; mem_addr = 32'h80; mem_wreg = 1'b1; dbus_ack = 1'b0;
      next_cycle();
      rst = 1'b1;
      #1;
      chk("rst_wait_outputs", all_outs(), 160'(0));
      next_cycle();
      rst = 1'b0; mem_op = 4'd0; mem_wdata = 32'h7777_0000; dbus_ack = 1'b1;
      dbus_rdata = 32'h1111_1111;
      #1;
      chk("rst_wait_after", 160'({dbus_req, stallreq_mem, wdata0}), 160'({2'b00, 32'h7777_0000}));
      next_cycle();
      dbus_ack = 1'b0;
      run_op("lw_after_rst", 4'd5, 32'h84, 32'h0, 32'h0123_4567, 1, 0, 1'b0, 1'b1);

      // Randomized ops against the model
      for (int n = 0; n < 60; n++) begin
         logic [3:0]  op;
         logic [31:0] addr;
         op = 4'($urandom_range(0, 15));
         addr = $urandom;
         if (issues(op, addr)) begin
            run_op($sformatf("rnd%0d", n), op, addr, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), 1'($urandom));
         end else begin
            mem_op = op; mem_addr = addr; mem_wdata = $urandom; mem_wreg = 1'($urandom);
            mem_wd = 5'($urandom); mem_pc = $urandom; mem_sdata = $urandom;
            dbus_ack = 1'($urandom);
            #1;
            check_passive($sformatf("rnd%0d", n));
            next_cycle();
            dbus_ack = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
